battle_turn_ctrl: RTL and testbench

//  Turn sequencer for the battle screen. Takes player commands from the UART key stream and

---
 rtl/battle_turn_ctrl.sv | 128 ++++++++++++
 tb/tb_battle_turn_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/battle_turn_ctrl.sv
// Battle-screen turn sequencer: menu commands, player act, monster dodge turns,
// hit damage with i-frames, HP bookkeeping and win/lose outcome.
module battle_turn_ctrl #(
    parameter int P_HP_MAX     = 100,
    parameter int MON_HP_MAX   = 100,
    parameter int ATK_DMG      = 10,
    parameter int HIT_DMG      = 5,
    parameter int HEAL_AMT     = 20,
    parameter int ATTACK_TICKS = 50,
    parameter int IFRAME_TICKS = 10,
    parameter int NUM_WAVES    = 4,
    parameter int WAVE_W       = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tick,
    input  logic              key_valid,
    input  logic [7:0]        key,
    input  logic              hit,
    output logic [2:0]        phase,
    output logic              bullet_run,
    output logic [WAVE_W-1:0] wave_idx,
    output logic [7:0]        player_hp,
    output logic [7:0]        mon_hp,
    output logic              win,
    output logic              lose
);

    localparam int TW = $clog2(ATTACK_TICKS);
    localparam int IW = $clog2(IFRAME_TICKS + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MENU  = 3'd1,
        S_ACT   = 3'd2,
        S_DODGE = 3'd3,
        S_WIN   = 3'd4,
        S_LOSE  = 3'd5
    } state_t;

    state_t          state;
    logic            act_heal;
    logic [TW-1:0]   tick_cnt;
    logic [IW-1:0]   iframe;

    logic [8:0]        mon_sub, hp_add, hp_sub;
    logic [7:0]        mon_after_atk, hp_after_heal, hp_after_hit;
    logic              hit_ok, restart;
    logic [WAVE_W-1:0] wave_next;

    assign phase = state;

    // 9-bit arithmetic so that underflow/overflow is visible before saturating
    always_comb begin
        mon_sub       = {1'b0, mon_hp} - 9'(ATK_DMG);
        hp_add        = {1'b0, player_hp} + 9'(HEAL_AMT);
        hp_sub        = {1'b0, player_hp} - 9'(HIT_DMG);
        mon_after_atk = mon_sub[8] ? '0 : mon_sub[7:0];
        hp_after_hit  = hp_sub[8] ? '0 : hp_sub[7:0];
        hp_after_heal = (hp_add > 9'(P_HP_MAX)) ? 8'(P_HP_MAX) : hp_add[7:0];
        hit_ok        = hit && (iframe == '0);
        wave_next     = (wave_idx == WAVE_W'(NUM_WAVES - 1)) ? '0 : wave_idx + WAVE_W'(1);
        restart       = (state == S_WIN || state == S_LOSE) && key_valid && (key == 8'h72);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n || restart) begin
            state      <= S_IDLE;
            act_heal   <= 1'b0;
            player_hp  <= 8'(P_HP_MAX);
            mon_hp     <= 8'(MON_HP_MAX);
            bullet_run <= 1'b0;
            wave_idx   <= '0;
            win        <= 1'b0;
            lose       <= 1'b0;
            iframe     <= '0;
            tick_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: if (key_valid) state <= S_MENU;
                S_MENU: begin
                    if (key_valid && (key == 8'h61 || key == 8'h68)) begin
                        state    <= S_ACT;
                        act_heal <= (key == 8'h68);
                    end
                end
                S_ACT: begin
                    if (!act_heal && mon_after_atk == '0) begin
                        mon_hp <= '0;
                        state  <= S_WIN;
                        win    <= 1'b1;
                    end else begin
                        if (act_heal) player_hp <= hp_after_heal;
                        else          mon_hp    <= mon_after_atk;
                        state      <= S_DODGE;
                        tick_cnt   <= '0;
                        iframe     <= '0;
                        bullet_run <= 1'b1;
                    end
                end
                S_DODGE: begin
                    if (tick) tick_cnt <= tick_cnt + TW'(1);
                    // an accepted hit reloads the i-frames even on a tick clk
                    if (hit_ok) begin
                        player_hp <= hp_after_hit;
                        iframe    <= IW'(IFRAME_TICKS);
                    end else if (tick && iframe != '0) begin
                        iframe <= iframe - IW'(1);
                    end
                    if (hit_ok && hp_after_hit == '0) begin
                        state      <= S_LOSE;
                        lose       <= 1'b1;
                        bullet_run <= 1'b0;
                        iframe     <= '0;
                    end else if (tick && tick_cnt == TW'(ATTACK_TICKS - 1)) begin
                        state      <= S_MENU;
                        bullet_run <= 1'b0;
                        wave_idx   <= wave_next;
                        iframe     <= '0;
                    end
                end
                S_WIN, S_LOSE: bullet_run <= 1'b0;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_battle_turn_ctrl.sv
// Scoreboard bench for battle_turn_ctrl: expected outputs are queued when a
// stimulus clk is driven and compared one edge later.
module tb_battle_turn_ctrl;

    localparam logic [2:0] PH_IDLE = 3'd0, PH_MENU = 3'd1, PH_ACT = 3'd2,
                           PH_DODGE = 3'd3, PH_WIN = 3'd4, PH_LOSE = 3'd5;
    localparam logic [7:0] K_A = 8'h61, K_H = 8'h68, K_R = 8'h72,
                           K_Q = 8'h71, K_X = 8'h78;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       tick = 1'b0;
    logic       key_valid = 1'b0;
    logic [7:0] key = '0;
    logic       hit = 1'b0;
    logic [2:0] phase;
    logic       bullet_run;
    logic [1:0] wave_idx;
    logic [7:0] player_hp, mon_hp;
    logic       win, lose;

    battle_turn_ctrl #(
        .P_HP_MAX(100), .MON_HP_MAX(100), .ATK_DMG(10), .HIT_DMG(5),
        .HEAL_AMT(20), .ATTACK_TICKS(50), .IFRAME_TICKS(10),
        .NUM_WAVES(4), .WAVE_W(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .tick(tick), .key_valid(key_valid),
        .key(key), .hit(hit), .phase(phase), .bullet_run(bullet_run),
        .wave_idx(wave_idx), .player_hp(player_hp), .mon_hp(mon_hp),
        .win(win), .lose(lose)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [2:0] ph;
        int         p;
        int         m;
        int         w;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    logic [2:0] exp_ph;
    int   exp_p, exp_m, exp_w;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic set_exp(input logic [2:0] ph, input int p, input int m, input int w);
        exp_ph = ph; exp_p = p; exp_m = m; exp_w = w;
    endtask

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag = tag; e.ph = exp_ph; e.p = exp_p; e.m = exp_m; e.w = exp_w;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            check_val("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check_val({e.tag, ".phase"}, 32'(phase), 32'(e.ph));
        check_val({e.tag, ".run"},   32'(bullet_run), 32'(e.ph == PH_DODGE));
        check_val({e.tag, ".win"},   32'(win),  32'(e.ph == PH_WIN));
        check_val({e.tag, ".lose"},  32'(lose), 32'(e.ph == PH_LOSE));
        check_val({e.tag, ".wave"},  32'(wave_idx), 32'(e.w));
        // HP during the single ACT clk is not pinned down; it is checked once ACT resolves
        if (e.ph != PH_ACT) begin
            check_val({e.tag, ".player_hp"}, 32'(player_hp), 32'(e.p));
            check_val({e.tag, ".mon_hp"},    32'(mon_hp),    32'(e.m));
        end
    endtask

    task automatic step(input logic kv, input logic [7:0] k, input logic tk,
                        input logic ht, input string tag);
        key_valid = kv; key = k; tick = tk; hit = ht;
        if (tag != "") push_exp(tag);
        @(posedge clk); #1;
        key_valid = 1'b0; tick = 1'b0; hit = 1'b0;
        if (tag != "") pop_check();
    endtask

    task automatic ticks(input int n, input logic ht);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, ht, "");
    endtask

    task automatic sparse_ticks(input int n, input logic ht);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 8'h00, 1'b0, ht, "");
            step(1'b0, 8'h00, 1'b1, ht, "");
        end
    endtask

    task automatic act(input logic [7:0] k, input string tag);
        exp_ph = PH_ACT;
        step(1'b1, k, 1'b0, 1'b0, {tag, "_act"});
        if (k == K_A) exp_m = (exp_m > 10) ? exp_m - 10 : 0;
        else          exp_p = (exp_p + 20 > 100) ? 100 : exp_p + 20;
        exp_ph = (exp_m == 0) ? PH_WIN : PH_DODGE;
        step(1'b0, 8'h00, 1'b0, 1'b0, tag);
    endtask

    // 49 quiet ticks, then the 50th tick closes the turn
    task automatic quiet_turn(input string tag);
        ticks(49, 1'b0);
        exp_ph = PH_MENU;
        exp_w  = (exp_w == 3) ? 0 : exp_w + 1;
        step(1'b0, 8'h00, 1'b1, 1'b0, tag);
    endtask

    initial begin
        #1 reset_n = 1'b0;
        #2;
        set_exp(PH_IDLE, 100, 100, 0);
        push_exp("reset"); pop_check();
        @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;

        // menu navigation and first attack turn
        exp_ph = PH_MENU; step(1'b1, K_Q, 1'b0, 1'b0, "key_q");
        step(1'b1, K_X, 1'b0, 1'b0, "key_x");
        step(1'b0, 8'h00, 1'b1, 1'b1, "menu_tick_hit");
        act(K_A, "atk1");
        ticks(49, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, "dodge_49");
        exp_ph = PH_MENU; exp_w = 1;
        step(1'b0, 8'h00, 1'b1, 1'b0, "turn1_end");

        // hit held through 25 sparse ticks: three accepted hits
        act(K_A, "atk2");
        sparse_ticks(25, 1'b1);
        exp_p = 85;
        step(1'b0, 8'h00, 1'b0, 1'b0, "held_hit");
        ticks(24, 1'b0);
        exp_ph = PH_MENU; exp_w = 2;
        step(1'b0, 8'h00, 1'b1, 1'b0, "turn2_end");

        // single hit pulse after 5 ticks
        act(K_A, "atk3");
        ticks(5, 1'b0);
        exp_p = 80;
        step(1'b0, 8'h00, 1'b0, 1'b1, "single_hit");
        ticks(44, 1'b0);
        exp_ph = PH_MENU; exp_w = 3;
        step(1'b0, 8'h00, 1'b1, 1'b0, "turn3_end");

        // heal 80->100, hit to 95, wave wraps 3->0
        act(K_H, "heal80");
        ticks(5, 1'b0);
        exp_p = 95;
        step(1'b0, 8'h00, 1'b0, 1'b1, "hit_to_95");
        ticks(44, 1'b0);
        exp_ph = PH_MENU; exp_w = 0;
        step(1'b0, 8'h00, 1'b1, 1'b0, "wave_wrap");

        // heal clamps at 100; hit held every clk: accepts at ticks 0,11,22,33,44
        act(K_H, "heal95_clamp");
        ticks(49, 1'b1);
        exp_ph = PH_MENU; exp_p = 75; exp_w = 1;
        step(1'b0, 8'h00, 1'b1, 1'b1, "held_turn");
        step(1'b0, 8'h00, 1'b1, 1'b1, "menu_hit_ignored");

        act(K_H, "heal75");
        ticks(49, 1'b1);
        exp_ph = PH_MENU; exp_p = 70; exp_w = 2;
        step(1'b0, 8'h00, 1'b1, 1'b1, "held_turn2");
        act(K_A, "atk_quiet");
        quiet_turn("quiet_end");
        act(K_A, "atk_g");
        ticks(49, 1'b1);
        exp_ph = PH_MENU; exp_p = 45; exp_w = 0;
        step(1'b0, 8'h00, 1'b1, 1'b1, "held_turn3");
        act(K_A, "atk_h");
        ticks(49, 1'b1);
        exp_ph = PH_MENU; exp_p = 20; exp_w = 1;
        step(1'b0, 8'h00, 1'b1, 1'b1, "held_turn4");

        // three hits to 5 HP, fatal hit on the 50th tick beats turn end
        act(K_A, "atk_lose");
        ticks(23, 1'b1);
        ticks(26, 1'b0);
        exp_p = 5;
        step(1'b0, 8'h00, 1'b0, 1'b0, "hp5");
        exp_ph = PH_LOSE; exp_p = 0;
        step(1'b0, 8'h00, 1'b1, 1'b1, "lose");
        step(1'b1, K_A, 1'b1, 1'b1, "lose_key_a");
        set_exp(PH_IDLE, 100, 100, 0);
        step(1'b1, K_R, 1'b0, 1'b0, "lose_restart");

        // wave sequence over full turns, then drain monster to 10
        exp_ph = PH_MENU; step(1'b1, K_Q, 1'b0, 1'b0, "menu2");
        for (int i = 0; i < 9; i++) begin
            act(K_A, "atk_loop");
            quiet_turn("loop_turn_end");
        end
        act(K_A, "kill");
        step(1'b0, 8'h00, 1'b1, 1'b1, "win_hold");
        step(1'b1, K_A, 1'b0, 1'b0, "win_key_a");
        set_exp(PH_IDLE, 100, 100, 0);
        step(1'b1, K_R, 1'b0, 1'b0, "win_restart");

        // async reset in the middle of a dodge turn
        exp_ph = PH_MENU; step(1'b1, K_Q, 1'b0, 1'b0, "menu3");
        act(K_A, "atk_rst");
        ticks(10, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        set_exp(PH_IDLE, 100, 100, 0);
        push_exp("async_reset"); pop_check();
        @(posedge clk); #1 reset_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

endmodule
